// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and default timing constants.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_GAP     = 3'd4
   } state_t;

   localparam int DEF_GAP      = 2;
   localparam int DEF_START_TO = 4;
   localparam int DEF_FRAME_TO = 64;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester above last_id, wrapping,
// so last_id itself wins only when nobody else is asking.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            valid,
   output logic [IDW-1:0]  id
);

   logic [IDW-1:0] idx_s;
   logic           found_s;

   // Scan NREQ positions starting just above last_id.
   always_comb begin
      valid   = |req;
      id      = last_id;
      found_s = 1'b0;
      idx_s   = last_id;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s = IDW'((int'(last_id) + k) % NREQ);
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            id      = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ requesters: round-robin grant,
// start/frame handshake supervision with timeouts, and an inter-frame gap.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int GAP      = DEF_GAP,
   parameter int START_TO = DEF_START_TO,
   parameter int FRAME_TO = DEF_FRAME_TO
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [8*NREQ-1:0]       req_data,
   output logic [NREQ-1:0]         ack,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [$clog2(NREQ)-1:0] cur_id,
   output logic                    busy,
   output logic                    err
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(max3(GAP, START_TO, FRAME_TO) + 1);

   state_t          state_r;
   state_t          state_s;
   state_t          post_s;
   logic [CW-1:0]   cnt_r;
   logic            pick_valid_s;
   logic [IDW-1:0]  pick_id_s;
   logic [NREQ-1:0] ack_s;
   logic [7:0]      tx_data_s;
   logic            tx_start_s;
   logic [IDW-1:0]  cur_id_s;
   logic            busy_s;
   logic            err_s;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req     (req),
      .last_id (cur_id),
      .valid   (pick_valid_s),
      .id      (pick_id_s)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_s    = state_r;
      ack_s      = '0;
      tx_start_s = 1'b0;
      tx_data_s  = tx_data;
      cur_id_s   = cur_id;
      err_s      = 1'b0;
      if (GAP == 0) begin
         post_s = ST_IDLE;
      end else begin
         post_s = ST_GAP;
      end
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_s          = ST_START;
               ack_s[pick_id_s] = 1'b1;
               tx_start_s       = 1'b1;
               tx_data_s        = req_data[{pick_id_s, 3'b000} +: 8];
               cur_id_s         = pick_id_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: state_s = ST_WAIT_HI;
         ST_WAIT_HI: begin
            if (tx_busy) begin
               state_s = ST_WAIT_LO;
            end else if (cnt_r >= CW'(START_TO - 1)) begin
               state_s = post_s;
               err_s   = 1'b1;
            end else begin
               state_s = ST_WAIT_HI;
            end
         end
         ST_WAIT_LO: begin
            if (!tx_busy) begin
               state_s = post_s;
            end else if (cnt_r >= CW'(FRAME_TO - 1)) begin
               state_s = post_s;
               err_s   = 1'b1;
            end else begin
               state_s = ST_WAIT_LO;
            end
         end
         ST_GAP: begin
            if (cnt_r >= CW'(GAP - 1)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, shared saturating counter (cleared on each state entry) and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         cur_id   <= IDW'(NREQ - 1);
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_r  <= state_s;
         if (state_s != state_r) begin
            cnt_r <= '0;
         end else if (cnt_r != {CW{1'b1}}) begin
            cnt_r <= cnt_r + CW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         ack      <= ack_s;
         tx_start <= tx_start_s;
         tx_data  <= tx_data_s;
         cur_id   <= cur_id_s;
         busy     <= busy_s;
         err      <= err_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level model.
module tb_uart_tx_sched;

   localparam int NREQ       = 4;
   localparam int GAP_B      = 2;
   localparam int START_TO_B = 4;
   localparam int FRAME_TO_B = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  cur_id;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.NREQ(NREQ), .GAP(GAP_B), .START_TO(START_TO_B), .FRAME_TO(FRAME_TO_B)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .cur_id   (cur_id),
      .busy     (busy),
      .err      (err)
   );

   typedef struct {
      logic [3:0] r;
      int         id;
      int         d;
      int         len;
   } vec_t;

   vec_t tbl[11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (last + k) % NREQ;
         if (r[j]) return j;
      end
      return last;
   endfunction

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; tx_busy = 1'b0;
      step(); step();
      chk("rst_ack", ack, 4'b0000);
      chk("rst_start", tx_start, 1'b0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_id", cur_id, 2'd3);
      rst = 1'b0;
   endtask

   // Called in an idle cycle: request r, expect grant exp_id, then model a
   // transmitter that raises tx_busy d cycles after tx_start for len cycles.
   task automatic xfer(input logic [3:0] r, input int exp_id, input int d, input int len);
      logic [7:0] eb;
      logic [3:0] oh;
      req = r;
      eb  = req_data[8*exp_id +: 8];
      oh  = 4'b0001 << exp_id;
      step();
      chk("x_ack", ack, oh);
      chk("x_start", tx_start, 1'b1);
      chk("x_data", tx_data, eb);
      chk("x_id", cur_id, exp_id);
      chk("x_busy", busy, 1'b1);
      req = r & ~oh;
      tx_busy = (d == 0);
      for (int k = 1; k <= d + len; k++) begin
         step();
         tx_busy = (k >= d && k < d + len);
      end
      for (int k = 1; k <= GAP_B; k++) step();
      chk("x_busy_gap", busy, 1'b1);
      step();
      chk("x_busy_idle", busy, 1'b0);
      chk("x_err", err, 1'b0);
      chk("x_hold", tx_data, eb);
   endtask

   initial begin
      int free_at, b_lo, b_hi, m_last, pend_id, g, d, len;
      bit pend, have_b;
      logic [7:0] pend_b, last_b;
      logic [3:0] rq;
      logic [7:0] bytes[4];

      rst = 1'b1; req = 4'b0000; req_data = 32'h0; tx_busy = 1'b0;
      tbl[0]  = '{4'b1111, 1, 1, 3};
      tbl[1]  = '{4'b1111, 2, 4, 1};
      tbl[2]  = '{4'b0001, 0, 2, 2};
      tbl[3]  = '{4'b0001, 0, 0, 2};
      tbl[4]  = '{4'b1001, 3, 3, 4};
      tbl[5]  = '{4'b0110, 1, 1, 1};
      tbl[6]  = '{4'b0100, 2, 4, 5};
      tbl[7]  = '{4'b1010, 3, 2, 1};
      tbl[8]  = '{4'b0011, 0, 1, 2};
      tbl[9]  = '{4'b1000, 3, 0, 3};
      tbl[10] = '{4'b1100, 2, 3, 3};

      do_reset();

      // Single request, 10-cycle frame.
      req_data = 32'h0000_005A;
      xfer(4'b0001, 0, 1, 10);

      for (int i = 0; i < 11; i++) begin
         req_data = $urandom();
         xfer(tbl[i].r, tbl[i].id, tbl[i].d, tbl[i].len);
      end

      // All four held: strict rotation starting at 0 after reset.
      do_reset();
      req_data = 32'hA3A2_A1A0;
      xfer(4'b1111, 0, 1, 2);
      xfer(4'b1111, 1, 1, 2);
      xfer(4'b1111, 2, 1, 2);
      xfer(4'b1111, 3, 1, 2);
      xfer(4'b1111, 0, 1, 2);
      req = 4'b0000;

      // Transmitter never answers; req[2] glitched and pulsed while busy.
      req_data = 32'h0000_0033; req = 4'b0001;
      step();
      chk("to_ack", ack, 4'b0001);
      req = 4'b0000; tx_busy = 1'b0;
      for (int k = 1; k <= START_TO_B; k++) begin
         step();
         chk("to_err_early", err, 1'b0);
         chk("to_busy", busy, 1'b1);
         if (k == 2) begin
            req[2] = 1'b1; #2; req[2] = 1'b0;
         end else if (k == 3) begin
            req = 4'b0100;
         end else begin
            req = 4'b0000;
         end
      end
      step();
      chk("to_err", err, 1'b1);
      chk("to_busy_gap", busy, 1'b1);
      step();
      chk("to_err_once", err, 1'b0);
      step();
      chk("to_idle", busy, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("no_ack2", ack, 4'b0000);
      end

      // Transmitter stuck busy for the whole frame budget.
      req_data = 32'h0000_0044; req = 4'b0001;
      step();
      chk("st_ack", ack, 4'b0001);
      req = 4'b0000; tx_busy = 1'b1;
      for (int k = 1; k <= FRAME_TO_B + 1; k++) begin
         step();
         chk("st_err_early", err, 1'b0);
      end
      step();
      chk("st_err", err, 1'b1);
      chk("st_busy", busy, 1'b1);
      tx_busy = 1'b0;
      step();
      chk("st_err_once", err, 1'b0);
      step();
      chk("st_idle", busy, 1'b0);

      // Asynchronous reset in the middle of a frame.
      req_data = 32'h0000_2211; req = 4'b0010;
      step();
      chk("ar_ack", ack, 4'b0010);
      req = 4'b0011;
      step(); tx_busy = 1'b1;
      step(); step();
      #3 rst = 1'b1;
      #1;
      chk("ar_ack0", ack, 4'b0000);
      chk("ar_start0", tx_start, 1'b0);
      chk("ar_data0", tx_data, 8'h00);
      chk("ar_busy0", busy, 1'b0);
      chk("ar_err0", err, 1'b0);
      chk("ar_id", cur_id, 2'd3);
      tx_busy = 1'b0;
      step();
      rst = 1'b0;
      xfer(4'b0011, 0, 1, 2);
      xfer(4'b0010, 1, 1, 2);
      req = 4'b0000;

      // Randomized traffic against a transaction-level model.
      do_reset();
      m_last = 3; free_at = 0; pend = 1'b0; have_b = 1'b0;
      b_lo = 1; b_hi = 0; rq = 4'b0000; pend_id = 0; pend_b = 8'h00; last_b = 8'h00;
      for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
      for (int c = 0; c < 800; c++) begin
         step();
         if (pend) begin
            chk("r_ack", ack, 4'b0001 << pend_id);
            chk("r_start", tx_start, 1'b1);
            chk("r_data", tx_data, pend_b);
            chk("r_id", cur_id, pend_id);
            chk("r_busy_start", busy, 1'b1);
            d   = $urandom_range(0, START_TO_B);
            len = $urandom_range(2, 12);
            b_lo = c + d; b_hi = c + d + len - 1;
            free_at = c + d + len + 1 + GAP_B;
            last_b = pend_b; have_b = 1'b1;
            rq[pend_id] = 1'b0;
            pend = 1'b0;
         end else begin
            chk("r_ack_idle", ack, 4'b0000);
            chk("r_start_idle", tx_start, 1'b0);
            chk("r_busy", busy, (c < free_at));
            chk("r_id_hold", cur_id, m_last);
            if (have_b) chk("r_data_hold", tx_data, last_b);
         end
         chk("r_err", err, 1'b0);
         tx_busy = (c >= b_lo && c <= b_hi);
         for (int i = 0; i < 4; i++) begin
            if (!rq[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  rq[i] = 1'b1;
                  bytes[i] = 8'($urandom());
               end
            end else if ($urandom_range(0, 15) == 0) begin
               rq[i] = 1'b0;
            end
         end
         req = rq;
         req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
         if (c >= free_at && rq != 4'b0000) begin
            g = rr(rq, m_last);
            pend = 1'b1; pend_id = g; pend_b = bytes[g];
            m_last = g; free_at = 1 << 30;
         end
      end
      req = 4'b0000; tx_busy = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
